mult18x18_0c: RTL and testbench
===============================

MULT18X18_0C -- requirements
Module: mult18x18_0c

Interface
REQ-001 Parameter LATENCY, default 0: number of register stages between A/B and O; legal values 0, 1, 2.
REQ-002 clk  input  1  single clock; all registers sample on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; clears pipeline registers while low.
REQ-004 en  input  1  clock enable for all pipeline registers; active-high.
REQ-005 A  input  18  signed two's-complement multiplicand.
REQ-006 B  input  18  signed two's-complement multiplier.
REQ-007 O  output  36  signed two's-complement product A*B; the parent sign-extends O when its port is wider.

Function
REQ-008 O SHALL equal the exact signed product A*B for all 2^36 input pairs, with no truncation, rounding or saturation.
REQ-009 The 36-bit width SHALL hold the full range: the most negative result is -131072*131071 = -17179738112, and the most positive is (-131072)*(-131072) = 17179869184 = 36'h4_0000_0000.
REQ-010 LATENCY=0: O SHALL be purely combinational from A and B, with zero clock cycles of latency; O SHALL NOT depend on clk, en or rst.
REQ-011 LATENCY=1: A and B SHALL be registered, and O SHALL be computed combinationally from the registered operands; O reflects inputs sampled 1 rising edge earlier.
REQ-012 LATENCY=2: input registers plus one register on the product; O reflects inputs sampled 2 rising edges earlier.
REQ-013 When en=0, every pipeline register SHALL hold its value, and O SHALL stay stable for LATENCY>0.
REQ-014 Datapath: radix-4 modified Booth recoding of B into 9 digits in {-2,-1,0,+1,+2}.
REQ-015 Each Booth digit SHALL select a partial product of A (0, ±A, ±2A), sign-extended to 36 bits; negation SHALL use invert plus a correction bit injected in the tree.
REQ-016 The 9 partial products and the correction bits SHALL be reduced by a carry-save (3:2 compressor) tree to two 36-bit vectors.
REQ-017 The two vectors SHALL be summed by one final 36-bit adder; carry-out beyond bit 35 SHALL be discarded.
REQ-018 The behavioural operator '*' SHALL NOT be used in synthesizable code; it SHALL be permitted only in verification models.
REQ-019 Boundary: A=-131072 with a Booth digit of -2 SHALL produce the correct magnitude 2^18 in the partial product; the 19-bit intermediate ±2A SHALL not overflow before sign extension.
REQ-020 Operand 0 on either input SHALL yield O=0 independent of the other operand.

Reset
REQ-021 While rst=0, all pipeline registers (operands and product) SHALL clear to 0 immediately, without waiting for a clock edge; for LATENCY>0, O=0.
REQ-022 Release of rst SHALL be synchronous to clk in effect: the first capture occurs on the first rising edge with rst=1 and en=1.
REQ-023 Reset asserted mid-operation SHALL discard in-flight products; no stale value SHALL appear after release.
REQ-024 For LATENCY=0, reset SHALL have no effect on O (no registers exist).

Structure
REQ-025 A shared package SHALL hold the constants A_W=18, B_W=18, P_W=36 and NUM_PP=9, plus the Booth digit encoding (neg, one, two select bits).
REQ-026 One sub-module mult18x18_booth_pp SHALL take A and one 3-bit Booth window and return a 36-bit partial product and its negate-correction bit.
REQ-027 The parent SHALL instantiate it 9 times, and SHALL hold the compressor tree, final adder and optional pipeline registers.

Verification
REQ-028 LATENCY=0: A=3, B=-5 -> O=-15 (36'hF_FFFF_FFF1) in the same delta cycle; A=0, B=-131072 -> O=0.
REQ-029 Corners: (-131072)*(-131072) -> 17179869184; 131071*131071 -> 17179607041; -131072*131071 -> -17179738112.
REQ-030 Random: at least 100k random signed pairs, plus all combinations of {0, 1, -1, 131071, -131072} -> O matches the reference model.
REQ-031 LATENCY=1 with en=1: apply A=100, B=-200 before an edge -> O=-20000 after that edge; drop en, change inputs -> O holds -20000.
REQ-032 LATENCY=2: drive rst=0 asynchronously mid-stream -> O=0 immediately; after release the first valid O appears 2 enabled edges later.

Source files
------------

// File: rtl/mult18x18_pkg.sv
// Shared constants, Booth select encoding and carry-save helper for the
// 18x18 signed Booth multiplier.
package mult18x18_pkg;

    localparam int A_W    = 18;
    localparam int B_W    = 18;
    localparam int P_W    = 36;
    localparam int NUM_PP = 9;

    // One Booth digit in {-2,-1,0,+1,+2}: magnitude select plus sign.
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_sel_t;

    typedef struct packed {
        logic [P_W-1:0] s;
        logic [P_W-1:0] c;
    } csa_t;

    // Window is {b[2i+1], b[2i], b[2i-1]}; digit = -2*w2 + w1 + w0.
    function automatic booth_sel_t booth_decode(input logic [2:0] win);
        booth_sel_t sel;
        sel.one = win[1] ^ win[0];
        sel.two = (win[2] & ~win[1] & ~win[0]) | (~win[2] & win[1] & win[0]);
        sel.neg = win[2] & ~(win[1] & win[0]);
        return sel;
    endfunction

    // 3:2 compressor across a whole vector; carry out of the top bit is
    // dropped because the product is taken modulo 2^36.
    function automatic csa_t csa(input logic [P_W-1:0] x,
                                 input logic [P_W-1:0] y,
                                 input logic [P_W-1:0] z);
        csa_t           r;
        logic [P_W-1:0] maj;
        maj = (x & y) | (x & z) | (y & z);
        r.s = x ^ y ^ z;
        r.c = {maj[P_W-2:0], 1'b0};
        return r;
    endfunction

endpackage

// File: rtl/mult18x18_booth_pp.sv
// One radix-4 Booth partial product: selects 0, +-A or +-2A from a 3-bit
// window of B and returns it sign-extended, with the negate correction bit.
module mult18x18_booth_pp
    import mult18x18_pkg::*;
(
    input  logic [A_W-1:0] a,
    input  logic [2:0]     win,
    output logic [P_W-1:0] pp,
    output logic           neg
);

    booth_sel_t             sel;
    logic signed [A_W:0]    mag;
    logic signed [A_W:0]    sel_val;

    assign sel = booth_decode(win);

    // 19 bits so that 2*(-131072) = -2^18 is representable before extension.
    always_comb begin
        mag = '0;
        if (sel.two)
            mag = {a, 1'b0};
        else if (sel.one)
            mag = {a[A_W-1], a};
        sel_val = sel.neg ? ~mag : mag;
    end

    assign pp  = {{(P_W-A_W-1){sel_val[A_W]}}, sel_val};
    assign neg = sel.neg;

endmodule

// File: rtl/mult18x18_0c.sv
// 18x18 signed multiplier: Booth partial products, carry-save reduction,
// one final adder, with 0, 1 or 2 optional register stages.
module mult18x18_0c
    import mult18x18_pkg::*;
#(
    parameter int LATENCY = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [17:0]   A,
    input  logic [17:0]   B,
    output logic [35:0]   O
);

    logic signed [A_W-1:0] a_op;
    logic signed [B_W-1:0] b_op;
    logic [B_W:0]          b_ext;
    logic [P_W-1:0]        pp   [NUM_PP];
    logic [NUM_PP-1:0]     neg;
    logic [P_W-1:0]        opnd [NUM_PP+1];
    csa_t                  l1   [3];
    csa_t                  l2   [2];
    csa_t                  l3;
    csa_t                  l4;
    csa_t                  l5;
    logic [P_W-1:0]        prod;

    // Implicit b[-1] = 0 below the LSB.
    assign b_ext = {b_op, 1'b0};

    for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
        mult18x18_booth_pp u_pp (
            .a   (a_op),
            .win (b_ext[2*i+2 -: 3]),
            .pp  (pp[i]),
            .neg (neg[i])
        );
    end

    // Correction bits sit at distinct even weights, so they share one row.
    always_comb begin
        for (int i = 0; i < NUM_PP; i++)
            opnd[i] = pp[i] << (2 * i);
        opnd[NUM_PP] = '0;
        for (int i = 0; i < NUM_PP; i++)
            opnd[NUM_PP][2*i] = neg[i];
    end

    // 10 rows -> 7 -> 5 -> 4 -> 3 -> 2.
    assign l1[0] = csa(opnd[0], opnd[1], opnd[2]);
    assign l1[1] = csa(opnd[3], opnd[4], opnd[5]);
    assign l1[2] = csa(opnd[6], opnd[7], opnd[8]);
    assign l2[0] = csa(l1[0].s, l1[0].c, l1[1].s);
    assign l2[1] = csa(l1[1].c, l1[2].s, l1[2].c);
    assign l3    = csa(l2[0].s, l2[0].c, l2[1].s);
    assign l4    = csa(l3.s, l3.c, l2[1].c);
    assign l5    = csa(l4.s, l4.c, opnd[NUM_PP]);

    assign prod = l5.s + l5.c;

    if (LATENCY == 0) begin : g_lat0
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clk, rst, en};
        assign a_op = A;
        assign b_op = B;
        assign O    = prod;
    end else begin : g_lat_reg
        logic signed [A_W-1:0] a_p0;
        logic signed [B_W-1:0] b_p0;

        // ---- stage p0: operand registers ----
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                a_p0 <= '0;
                b_p0 <= '0;
            end else if (en) begin
                a_p0 <= A;
                b_p0 <= B;
            end
        end

        assign a_op = a_p0;
        assign b_op = b_p0;

        if (LATENCY == 1) begin : g_lat1
            assign O = prod;
        end else begin : g_lat2
            logic [P_W-1:0] prod_p1;

            // ---- stage p1: product register ----
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    prod_p1 <= '0;
                else if (en)
                    prod_p1 <= prod;
            end

            assign O = prod_p1;
        end
    end

endmodule

// File: tb/tb_mult18x18_0c.sv
// Bench for mult18x18_0c: latency 0, 1 and 2 instances driven from shared
// inputs and checked against a plain integer product model.
module tb_mult18x18_0c;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [17:0] a   = '0;
    logic [17:0] b   = '0;
    logic [35:0] o0, o1, o2;

    int checks = 0;
    int errors = 0;

    logic [35:0] q1 [$];
    logic [35:0] q2 [$];
    logic [35:0] last1 = '0;
    logic [35:0] last2 = '0;
    logic        mon_en, mon_rst;
    logic [17:0] corner_vals [5];

    always #5 clk = ~clk;

    mult18x18_0c #(.LATENCY(0)) dut0 (.clk(clk), .rst(rst), .en(en), .A(a), .B(b), .O(o0));
    mult18x18_0c #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .en(en), .A(a), .B(b), .O(o1));
    mult18x18_0c #(.LATENCY(2)) dut2 (.clk(clk), .rst(rst), .en(en), .A(a), .B(b), .O(o2));

    function automatic logic [35:0] ref_prod(input logic [17:0] x, input logic [17:0] y);
        longint sx, sy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = sx * sy;
        return p[35:0];
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: each enabled edge retires the oldest outstanding product.
    always @(posedge clk) begin
        mon_en  = en;
        mon_rst = rst;
        #1;
        if (!mon_rst) begin
            last1 = '0;
            last2 = '0;
            check("l1_in_reset", o1, last1);
            check("l2_in_reset", o2, last2);
        end else if (mon_en) begin
            if (q1.size() > 0) begin
                last1 = q1.pop_front();
                check("l1_out", o1, last1);
            end else begin
                checks++;
                errors++;
                $display("FAIL l1_queue got empty required entry");
            end
            if (q2.size() >= 2)
                last2 = q2.pop_front();
            else
                last2 = '0;
            check("l2_out", o2, last2);
        end else begin
            check("l1_hold", o1, last1);
            check("l2_hold", o2, last2);
        end
    end

    task automatic issue(input logic [17:0] x, input logic [17:0] y);
        a = x;
        b = y;
        if (en) begin
            q1.push_back(ref_prod(x, y));
            q2.push_back(ref_prod(x, y));
        end
    endtask

    initial begin
        corner_vals[0] = 18'h00000;
        corner_vals[1] = 18'h00001;
        corner_vals[2] = 18'h3FFFF;
        corner_vals[3] = 18'h1FFFF;
        corner_vals[4] = 18'h20000;

        #1 rst = 1'b0;
        #1;
        check("reset_l1", o1, 36'h0);
        check("reset_l2", o2, 36'h0);

        a = 18'd3; b = -18'sd5; #1;
        check("l0_3_x_m5", o0, 36'hF_FFFF_FFF1);
        a = 18'd0; b = 18'h20000; #1;
        check("l0_zero_a", o0, 36'h0);
        a = 18'h20000; b = 18'h20000; #1;
        check("l0_min_x_min", o0, 36'h4_0000_0000);
        a = 18'h1FFFF; b = 18'h1FFFF; #1;
        check("l0_max_x_max", o0, 36'h3_FFFC_0001);
        a = 18'h20000; b = 18'h1FFFF; #1;
        check("l0_min_x_max", o0, 36'hC_0002_0000);

        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                a = corner_vals[i];
                b = corner_vals[j];
                #1;
                check("l0_corner", o0, ref_prod(a, b));
            end

        for (int i = 0; i < 100000; i++) begin
            a = 18'($urandom());
            b = 18'($urandom());
            #1;
            check("l0_rand", o0, ref_prod(a, b));
        end

        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        issue(18'd100, -18'sd200);
        @(posedge clk); #2;
        check("l1_100_x_m200", o1, 36'hF_FFFF_B1E0);
        @(negedge clk);
        en = 1'b0;
        issue(18'($urandom()), 18'($urandom()));
        @(posedge clk); #2;
        check("l1_en_low_hold", o1, 36'hF_FFFF_B1E0);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                @(posedge clk); #3;
                rst = 1'b0;
                #1;
                check("async_rst_l1", o1, 36'h0);
                check("async_rst_l2", o2, 36'h0);
                check("l0_ignores_rst", o0, ref_prod(a, b));
                q1.delete();
                q2.delete();
                last1 = '0;
                last2 = '0;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b1;
            end else begin
                @(negedge clk);
            end
            en = ($urandom_range(3) != 0);
            if ($urandom_range(7) == 0)
                issue(corner_vals[$urandom_range(4)], corner_vals[$urandom_range(4)]);
            else
                issue(18'($urandom()), 18'($urandom()));
        end

        @(negedge clk);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
